// File: rtl/axil_wr_guard.sv
// Single-outstanding AXI4-Lite write guard: captures one AW/W pair, replays it downstream and
// converts a hung slave into SLVERR. Optional statistics counters under AXIL_WR_GUARD_STATS_EN.
module axil_wr_guard #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  // upstream (from init master)
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  // downstream (to core)
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  // status
  input  logic              err_clr,
  output logic              err_timeout,
  output logic              err_resp,
  output logic              busy,
  output logic [15:0]       wr_count,
  output logic [15:0]       err_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP, ST_RETURN} state_e;

  state_e            state_q, state_d;
  logic              rdy_en_q, rdy_en_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        strb_q, strb_d;
  logic              awv_q, awv_d;
  logic              wv_q, wv_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [CW-1:0]     tcnt_q, tcnt_d;
  logic              stale_q, stale_d;
  logic              err_to_q, err_to_d;
  logic              err_rs_q, err_rs_d;
  logic              to_set, rs_set;
  logic              aw_done, w_done;

  always_comb begin
    state_d       = state_q;
    rdy_en_d      = 1'b1;
    aw_held_d     = aw_held_q;
    w_held_d      = w_held_q;
    addr_d        = addr_q;
    data_d        = data_q;
    strb_d        = strb_q;
    awv_d         = awv_q;
    wv_d          = wv_q;
    bresp_d       = bresp_q;
    tcnt_d        = tcnt_q;
    stale_d       = stale_q;
    to_set        = 1'b0;
    rs_set        = 1'b0;
    aw_done       = !awv_q || m_axi_awready;
    w_done        = !wv_q || m_axi_wready;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    m_axi_bready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // rdy_en_q keeps both readies low for the first cycle out of reset
        s_axi_awready = rdy_en_q && !aw_held_q;
        s_axi_wready  = rdy_en_q && !w_held_q;
        if (s_axi_awvalid && s_axi_awready) begin
          aw_held_d = 1'b1;
          addr_d    = s_axi_awaddr;
        end
        if (s_axi_wvalid && s_axi_wready) begin
          w_held_d = 1'b1;
          data_d   = s_axi_wdata;
          strb_d   = s_axi_wstrb;
        end
        // late response from a previously timed-out write is swallowed here
        m_axi_bready = stale_q;
        if (stale_q && m_axi_bvalid) stale_d = 1'b0;
        if (aw_held_d && w_held_d) begin
          state_d = ST_ISSUE;
          awv_d   = 1'b1;
          wv_d    = 1'b1;
          tcnt_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (awv_q && m_axi_awready) awv_d = 1'b0;
        if (wv_q && m_axi_wready)   wv_d  = 1'b0;
        tcnt_d = tcnt_q + 1'b1;
        if (aw_done && w_done) begin
          state_d = ST_RESP;
          tcnt_d  = '0;
        end else if (tcnt_q == TLAST) begin
          awv_d   = 1'b0;
          wv_d    = 1'b0;
          bresp_d = 2'b10;
          to_set  = 1'b1;
          stale_d = aw_done || w_done;
          state_d = ST_RETURN;
        end
      end
      ST_RESP: begin
        m_axi_bready = 1'b1;
        tcnt_d       = tcnt_q + 1'b1;
        if (m_axi_bvalid) begin
          bresp_d = m_axi_bresp;
          rs_set  = |m_axi_bresp;
          state_d = ST_RETURN;
        end else if (tcnt_q == TLAST) begin
          bresp_d = 2'b10;
          to_set  = 1'b1;
          stale_d = 1'b1;
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_to_d = to_set || (err_to_q && !err_clr);
    err_rs_d = rs_set || (err_rs_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= 4'h0;
      awv_q     <= 1'b0;
      wv_q      <= 1'b0;
      bresp_q   <= 2'b00;
      tcnt_q    <= '0;
      stale_q   <= 1'b0;
      err_to_q  <= 1'b0;
      err_rs_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_en_q  <= rdy_en_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      awv_q     <= awv_d;
      wv_q      <= wv_d;
      bresp_q   <= bresp_d;
      tcnt_q    <= tcnt_d;
      stale_q   <= stale_d;
      err_to_q  <= err_to_d;
      err_rs_q  <= err_rs_d;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awv_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = strb_q;
  assign m_axi_wvalid  = wv_q;
  assign s_axi_bresp   = bresp_q;
  assign err_timeout   = err_to_q;
  assign err_resp      = err_rs_q;
  assign busy          = (state_q != ST_IDLE);

`ifdef AXIL_WR_GUARD_STATS_EN
  logic [15:0] wr_cnt_q, err_cnt_q;

  // saturating counters, advanced on the upstream B handshake only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= 16'h0000;
      err_cnt_q <= 16'h0000;
    end else if (s_axi_bvalid && s_axi_bready) begin
      if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'h0001;
      if ((bresp_q != 2'b00) && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'h0001;
    end
  end

  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign wr_count  = 16'h0000;
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_axil_wr_guard.sv
// Directed bench for axil_wr_guard with a small configurable downstream slave model.
module tb_axil_wr_guard;
  localparam int T = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid;
  logic [1:0]  s_axi_bresp;
  logic [31:0] m_axi_awaddr, m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        err_clr = 1'b0, err_timeout, err_resp, busy;
  logic [15:0] wr_count, err_count;

  int errors = 0, checks = 0;

  axil_wr_guard #(.ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .err_clr(err_clr), .err_timeout(err_timeout), .err_resp(err_resp), .busy(busy),
    .wr_count(wr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // downstream slave: configurable awready delay, response on/off, late B on request
  int          aw_delay = 0, awwait = 0, b_cnt = 0, late_req = 0, late_ack = 0;
  bit          b_en = 1'b1, aw_ok = 1'b0, w_ok = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic [31:0] cap_addr = '0, cap_data = '0;
  logic [3:0]  cap_strb = '0;

  always begin
    @(posedge clk);
    if (!rst_n) begin
      aw_ok = 1'b0; w_ok = 1'b0; awwait = 0; late_ack = late_req;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin cap_addr = m_axi_awaddr; aw_ok = 1'b1; end
      if (m_axi_wvalid && m_axi_wready) begin
        cap_data = m_axi_wdata; cap_strb = m_axi_wstrb; w_ok = 1'b1;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        aw_ok = 1'b0; w_ok = 1'b0; late_ack = late_req; b_cnt++;
      end
      awwait = (m_axi_awvalid && !m_axi_awready) ? awwait + 1 : 0;
    end
    #1;
    m_axi_awready = (awwait >= aw_delay);
    m_axi_wready  = 1'b1;
    m_axi_bvalid  = (b_en && aw_ok && w_ok) || (late_req != late_ack);
    m_axi_bresp   = (late_req != late_ack) ? 2'b00 : b_resp_cfg;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  task automatic wait_bvalid(input int maxc, output int cyc, output bit ok);
    cyc = 0;
    while (s_axi_bvalid !== 1'b1 && cyc < maxc) begin tick(); cyc++; end
    ok = (s_axi_bvalid === 1'b1);
  endtask

  task automatic ack_b();
    s_axi_bready = 1'b1; tick(); s_axi_bready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
         busy, err_timeout, err_resp} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {s_axi_awready, s_axi_wready,
        s_axi_bvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, err_timeout, err_resp});
    end
    checks++;
    if (m_axi_awaddr !== 32'h0 || m_axi_wdata !== 32'h0 || m_axi_wstrb !== 4'h0 || s_axi_bresp !== 2'b00) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h/%h expected zeros",
        m_axi_awaddr, m_axi_wdata, m_axi_wstrb, s_axi_bresp);
    end
    checks++;
    if (wr_count !== 16'h0 || err_count !== 16'h0) begin
      errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", wr_count, err_count);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
      errors++; $display("FAIL idle_ready: got %b expected 11", {s_axi_awready, s_axi_wready});
    end
  endtask

  task automatic test_single();
    s_axi_awaddr = 32'h404; s_axi_wdata = 32'h1000_0010; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, busy} !== 3'b111 || m_axi_awaddr !== 32'h404 ||
        m_axi_wdata !== 32'h1000_0010 || m_axi_wstrb !== 4'hF) begin
      errors++; $display("FAIL single_issue: got v=%b a=%h d=%h s=%h expected 111/404/10000010/f",
        {m_axi_awvalid, m_axi_wvalid, busy}, m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
    end
    tick();
    checks++;
    if ({s_axi_bvalid, m_axi_bready, m_axi_awvalid, m_axi_wvalid} !== 4'b0100) begin
      errors++; $display("FAIL single_resp_phase: got %b expected 0100",
        {s_axi_bvalid, m_axi_bready, m_axi_awvalid, m_axi_wvalid});
    end
    tick();
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
      errors++; $display("FAIL single_bvalid_lat3: got v=%b r=%b expected 1/00", s_axi_bvalid, s_axi_bresp);
    end
    checks++;
    if (cap_addr !== 32'h404 || cap_data !== 32'h1000_0010 || cap_strb !== 4'hF) begin
      errors++; $display("FAIL single_downstream: got %h/%h/%h expected 404/10000010/f",
        cap_addr, cap_data, cap_strb);
    end
    ack_b();
    checks++;
    if ({busy, s_axi_bvalid, err_timeout, err_resp} !== 4'b0000) begin
      errors++; $display("FAIL single_done: got %b expected 0000", {busy, s_axi_bvalid, err_timeout, err_resp});
    end
  endtask

  task automatic test_w_first();
    int  cyc;
    bit  ok, early;
    aw_delay = 7;
    s_axi_wdata = 32'hCAFE_F00D; s_axi_wstrb = 4'h3; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    checks++;
    if ({s_axi_awready, s_axi_wready} !== 2'b10) begin
      errors++; $display("FAIL wfirst_readies: got %b expected 10", {s_axi_awready, s_axi_wready});
    end
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || busy !== 1'b0) early = 1'b1;
      tick();
    end
    checks++;
    if (early) begin errors++; $display("FAIL wfirst_early_valid: got 1 expected 0"); end
    s_axi_awaddr = 32'h808; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin
      errors++; $display("FAIL wfirst_issue: got %b expected 11", {m_axi_awvalid, m_axi_wvalid});
    end
    tick();
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid} !== 2'b10) begin
      errors++; $display("FAIL wfirst_w_drop: got %b expected 10", {m_axi_awvalid, m_axi_wvalid});
    end
    wait_bvalid(40, cyc, ok);
    checks++;
    if (!ok || s_axi_bresp !== 2'b00 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL wfirst_b: got ok=%0d r=%b to=%b expected 1/00/0", ok, s_axi_bresp, err_timeout);
    end
    checks++;
    if (cap_addr !== 32'h808 || cap_data !== 32'hCAFE_F00D || cap_strb !== 4'h3) begin
      errors++; $display("FAIL wfirst_downstream: got %h/%h/%h expected 808/cafef00d/3",
        cap_addr, cap_data, cap_strb);
    end
    ack_b();
    aw_delay = 0;
  endtask

  task automatic test_timeout();
    int cyc, b0;
    bit ok, leak;
    b_en = 1'b0;
    start_write(32'h10C, 32'h1, 4'hF);
    tick();
    wait_bvalid(40, cyc, ok);
    checks++;
    if (!ok || cyc != T) begin
      errors++; $display("FAIL timeout_latency: got ok=%0d cyc=%0d expected 1/%0d", ok, cyc, T);
    end
    checks++;
    if (s_axi_bresp !== 2'b10 || err_timeout !== 1'b1 || err_resp !== 1'b0) begin
      errors++; $display("FAIL timeout_resp: got r=%b to=%b rs=%b expected 10/1/0",
        s_axi_bresp, err_timeout, err_resp);
    end
    ack_b();
    checks++;
    if ({m_axi_bready, busy} !== 2'b10) begin
      errors++; $display("FAIL stale_drain_ready: got %b expected 10", {m_axi_bready, busy});
    end
    b0 = b_cnt;
    late_req++;
    tick(); tick();
    checks++;
    if (m_axi_bready !== 1'b0 || b_cnt != b0 + 1) begin
      errors++; $display("FAIL stale_absorb: got bready=%b taken=%0d expected 0/1", m_axi_bready, b_cnt - b0);
    end
    leak = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (s_axi_bvalid !== 1'b0 || busy !== 1'b0) leak = 1'b1;
      tick();
    end
    checks++;
    if (leak) begin errors++; $display("FAIL stale_forwarded: got 1 expected 0"); end
    b_en = 1'b1;
  endtask

  task automatic test_resp_err();
    int cyc;
    bit ok;
    b_resp_cfg = 2'b10;
    start_write(32'h20, 32'hDEAD_BEEF, 4'hF);
    wait_bvalid(10, cyc, ok);
    checks++;
    if (!ok || s_axi_bresp !== 2'b10 || err_resp !== 1'b1) begin
      errors++; $display("FAIL resp_err_fwd: got ok=%0d r=%b rs=%b expected 1/10/1", ok, s_axi_bresp, err_resp);
    end
    ack_b();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if ({err_resp, err_timeout} !== 2'b00) begin
      errors++; $display("FAIL err_clr: got %b expected 00", {err_resp, err_timeout});
    end
    start_write(32'h24, 32'h0, 4'h1);
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if ({err_resp, s_axi_bvalid} !== 2'b11) begin
      errors++; $display("FAIL set_beats_clr: got %b expected 11", {err_resp, s_axi_bvalid});
    end
    ack_b();
    b_resp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    b_en = 1'b0;
    start_write(32'h100, 32'h1234, 4'hF);
    tick();
    checks++;
    if ({m_axi_bready, busy} !== 2'b11) begin
      errors++; $display("FAIL mid_in_resp: got %b expected 11", {m_axi_bready, busy});
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy} !== 7'b0 ||
        m_axi_awaddr !== 32'h0 || m_axi_wdata !== 32'h0 || m_axi_wstrb !== 4'h0) begin
      errors++; $display("FAIL mid_async_reset: got %b a=%h d=%h expected 0",
        {s_axi_awready, s_axi_wready, s_axi_bvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy},
        m_axi_awaddr, m_axi_wdata);
    end
    tick();
    rst_n = 1'b1;
    tick();
    b_en = 1'b1;
    start_write(32'h200, 32'h55AA, 4'hC);
    wait_bvalid(10, cyc, ok);
    checks++;
    if (!ok || cyc != 2 || s_axi_bresp !== 2'b00 || cap_addr !== 32'h200 || cap_data !== 32'h55AA) begin
      errors++; $display("FAIL mid_next_write: got ok=%0d cyc=%0d r=%b a=%h d=%h expected 1/2/00/200/55aa",
        ok, cyc, s_axi_bresp, cap_addr, cap_data);
    end
    ack_b();
  endtask

  task automatic test_stats();
    int cyc;
    bit ok;
    logic [15:0] exp_wr, exp_err;
    #3 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      start_write(32'h300 + 32'(i * 4), 32'(i), 4'hF);
      wait_bvalid(10, cyc, ok);
      ack_b();
    end
    b_en = 1'b0;
    start_write(32'h310, 32'h9, 4'hF);
    wait_bvalid(40, cyc, ok);
    ack_b();
`ifdef AXIL_WR_GUARD_STATS_EN
    exp_wr = 16'd4; exp_err = 16'd1;
`else
    exp_wr = 16'd0; exp_err = 16'd0;
`endif
    checks++;
    if (wr_count !== exp_wr || err_count !== exp_err) begin
      errors++; $display("FAIL stats: got wr=%0d err=%0d expected %0d/%0d", wr_count, err_count, exp_wr, exp_err);
    end
    b_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_w_first();
    test_timeout();
    test_resp_err();
    test_reset_mid();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
